fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the program-counter register and a single-outstanding instruction-memory request port.
- Generates the PC register's next-value and stallF inputs.
- Issues one fetch at a time, handles branch/jump redirects from EX and kills stale in-flight responses.
- Presents fetched instructions to the IF/ID stage through a one-entry output register with hold back-pressure.

---
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and
// the instruction memory. One request may be outstanding at a time.
//   imem_req    : fetch request, address imem_addr (master -> slave)
//   imem_addr   : fetch address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : response valid (slave -> master)
//   imem_rdata  : response instruction word (slave -> master)
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer.
// Drives the PC register (pc_next/stallF), issues one instruction-memory
// fetch at a time, handles EX-stage redirects (killing stale in-flight
// responses) and presents fetched words to IF/ID through a one-entry output
// register that holds while the hazard unit asserts hold.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc_q            : current PC from the PC register
//   pc_next, stallF : PC register data input and hold (1 = keep pc_q)
//   imem            : instruction-memory bus (master side)
//   redirect_valid  : EX-stage taken branch/jump, target redirect_pc
//   hold            : IF/ID stall
//   instr_valid, instr, instr_pc : output register towards IF/ID
//   misaligned      : one-cycle pulse after a redirect with target[1:0] != 0
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic        [31:0] pc_q,
  output logic        [31:0] pc_next,
  output logic               stallF,
  fetch_ctrl_if.master       imem,
  input  logic               redirect_valid,
  input  logic        [31:0] redirect_pc,
  input  logic               hold,
  output logic               instr_valid,
  output logic        [31:0] instr,
  output logic        [31:0] instr_pc,
  output logic               misaligned
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   kill;
  logic   slot_free;
  logic   redir_act;
  logic   issue;
  logic   accept;

  // A request may only go out when its response is guaranteed a free slot,
  // and never in a redirect cycle so a grant always belongs to a live PC.
  assign slot_free = !instr_valid || !hold;
  assign redir_act = redirect_valid && (state != S_BOOT);
  assign issue     = (state == S_REQ) && slot_free && !redirect_valid;
  assign accept    = (state == S_WAIT) && imem.imem_rvalid && !kill && !redirect_valid;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_REQ;
      S_REQ:   if (issue && imem.imem_gnt) state_nxt = S_WAIT;
      S_WAIT:  if (imem.imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_BOOT;
    endcase
  end

  // ---- output logic ----
  // Priority: boot load, then redirect, then response advance, else hold PC.
  always_comb begin
    imem.imem_req  = issue;
    imem.imem_addr = pc_q;
    pc_next        = pc_q;
    stallF         = 1'b1;
    if (state == S_BOOT) begin
      pc_next = RESET_PC;
      stallF  = 1'b0;
    end else if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
      stallF  = 1'b0;
    end else if (accept) begin
      pc_next = pc_q + 32'd4;
      stallF  = 1'b0;
    end
  end

  // ---- kill flag, output register, misaligned pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      misaligned  <= 1'b0;
    end else begin
      misaligned <= redir_act && (redirect_pc[1:0] != 2'b00);

      // The response of a fetch redirected away while in flight is stale;
      // remember that until it arrives so it can be dropped.
      if (state == S_WAIT) begin
        if (imem.imem_rvalid)   kill <= 1'b0;
        else if (redirect_valid) kill <= 1'b1;
      end

      if (redir_act) begin
        instr_valid <= 1'b0;
      end else if (accept) begin
        instr_valid <= 1'b1;
        instr       <= imem.imem_rdata;
        instr_pc    <= pc_q;
      end else if (instr_valid && !hold) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc_q = 32'hFFFF_FFF0;
  logic [31:0] pc_next;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;

  fetch_ctrl_if imem ();

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_q           (pc_q),
    .pc_next        (pc_next),
    .stallF         (stallF),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hold           (hold),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misaligned     (misaligned)
  );

  // PC register model
  always @(posedge clk) if (!stallF) pc_q <= pc_next;

  // Memory model drive
  logic        gnt_en;
  logic        rvalid_m;
  logic        stray;
  logic [31:0] rdata_d;
  assign imem.imem_gnt    = gnt_en;
  assign imem.imem_rvalid = rvalid_m | stray;
  assign imem.imem_rdata  = rdata_d;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic        outstanding, stale;
  int          wait_cnt, lat;
  logic [31:0] req_addr;

  logic        c_rst, c_redir, c_rv_m, c_acc, c_valid, c_hold;
  logic [31:0] c_addr, c_instr, c_instr_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample settled outputs mid-cycle.
  task automatic settle();
    @(negedge clk);
    c_rst      = rst;
    c_redir    = redirect_valid;
    c_rv_m     = rvalid_m;
    c_acc      = imem.imem_req && imem.imem_gnt;
    c_addr     = imem.imem_addr;
    c_valid    = instr_valid;
    c_hold     = hold;
    c_instr    = instr;
    c_instr_pc = instr_pc;
  endtask

  // Cross the clock edge, update the memory model and scoreboard.
  task automatic advance();
    @(posedge clk);
    #1;
    if (c_rst) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end else begin
      if (c_rv_m) begin
        if (!stale && !c_redir) sb.push_back('{req_addr, mem_word(req_addr)});
        outstanding = 1'b0;
        stale       = 1'b0;
      end else if (c_redir && outstanding) begin
        stale = 1'b1;
      end
      if (c_acc) begin
        outstanding = 1'b1;
        wait_cnt    = lat;
        req_addr    = c_addr;
      end
    end

    if (!c_rst && !c_redir && c_valid && c_hold) begin
      check("hold_instr", instr, c_instr);
      check("hold_instr_pc", instr_pc, c_instr_pc);
      check("hold_valid", instr_valid, 1);
    end

    if (instr_valid && !c_valid) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", instr, e.data);
        check("sb_instr_pc", instr_pc, e.pc);
      end
    end

    if (outstanding) begin
      if (wait_cnt <= 1) begin
        rvalid_m = 1'b1;
        rdata_d  = stale ? 32'hDEAD_BEEF : mem_word(req_addr);
      end else begin
        rvalid_m = 1'b0;
        wait_cnt--;
      end
    end else begin
      rvalid_m = 1'b0;
    end
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic fetch_one(input string tag, input logic [31:0] addr);
    settle();
    check({tag, "_req"}, imem.imem_req, 1);
    check({tag, "_addr"}, imem.imem_addr, addr);
    advance();
    settle();
    advance();
    check({tag, "_instr_pc"}, instr_pc, addr);
    check({tag, "_valid"}, instr_valid, 1);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    gnt_en = 1'b1; rvalid_m = 1'b0; stray = 1'b0; rdata_d = '0;
    lat = 1; outstanding = 1'b0; stale = 1'b0; wait_cnt = 0; req_addr = '0;

    // Boot
    cyc(); cyc();
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misaligned", misaligned, 0);
    rst = 1'b0;
    settle();
    check("boot_pc_next", pc_next, RESET_PC);
    check("boot_stallF", stallF, 0);
    check("boot_req", imem.imem_req, 0);
    advance();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("seq_req", imem.imem_req, 1);
      check("seq_addr", imem.imem_addr, 32'(4 * k));
      check("seq_idle_stallF", stallF, 1);
      advance();
      settle();
      check("seq_resp_stallF", stallF, 0);
      check("seq_pc_next", pc_next, 32'(4 * k + 4));
      advance();
      check("seq_instr_pc", instr_pc, 32'(4 * k));
    end

    // Back-pressure
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_req", imem.imem_req, 0);
      check("bp_stallF", stallF, 1);
      check("bp_pc", pc_q, 32'h0000_000C);
      advance();
    end
    check("bp_instr_pc", instr_pc, 32'h0000_0008);
    hold = 1'b0;
    fetch_one("bp_release", 32'h0000_000C);

    // Kill of a response in flight during a redirect
    lat = 3;
    settle();
    check("kill_issue_addr", imem.imem_addr, 32'h0000_0010);
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    settle();
    check("kill_redir_pc_next", pc_next, 32'h0000_0100);
    check("kill_redir_stallF", stallF, 0);
    check("kill_redir_req", imem.imem_req, 0);
    advance();
    redirect_valid = 1'b0;
    settle();
    check("kill_wait_stallF", stallF, 1);
    advance();
    settle();
    check("kill_drop_rvalid", imem.imem_rvalid, 1);
    check("kill_drop_stallF", stallF, 1);
    check("kill_drop_pc_next", pc_next, 32'h0000_0100);
    advance();
    check("kill_valid", instr_valid, 0);
    lat = 1;
    fetch_one("kill_refetch", 32'h0000_0100);

    // Response and redirect in the same cycle
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    settle();
    check("same_rvalid", imem.imem_rvalid, 1);
    check("same_pc_next", pc_next, 32'h0000_0200);
    check("same_stallF", stallF, 0);
    advance();
    check("same_valid", instr_valid, 0);
    check("same_misaligned", misaligned, 0);
    settle();
    check("redir_gnt_req", imem.imem_req, 0);
    check("redir_gnt_pc_next", pc_next, 32'h0000_0200);
    advance();
    redirect_valid = 1'b0;
    fetch_one("same_refetch", 32'h0000_0200);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    settle();
    check("mis_pc_next", pc_next, 32'h0000_0100);
    check("mis_before", misaligned, 0);
    advance();
    redirect_valid = 1'b0;
    check("mis_pulse", misaligned, 1);
    check("mis_valid_cleared", instr_valid, 0);
    cyc();
    check("mis_pulse_end", misaligned, 0);

    // Reset while a fetch is outstanding, stray response during boot
    lat = 4;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; stray = 1'b1; rdata_d = 32'hBAD0_BAD0;
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_instr", instr, 0);
    settle();
    check("mid_boot_pc_next", pc_next, RESET_PC);
    check("mid_boot_stallF", stallF, 0);
    check("mid_boot_req", imem.imem_req, 0);
    advance();
    stray = 1'b0;
    check("mid_stray_valid", instr_valid, 0);
    lat = 1;
    fetch_one("mid_restart", RESET_PC);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      hold           = ($urandom_range(0, 2) == 0);
      gnt_en         = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cyc();
    end
    hold = 1'b0; gnt_en = 1'b1; redirect_valid = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
